uart_rx_monitor: RTL and testbench

Synthesizable, parametrised UART receive monitor with a receive FIFO, intended as the successor of the fixed-rate behavioural serial terminal used on the SoC benches. It samples a UART TX line from the SoC at a configurable bit rate and frame format. It checks start, parity and stop bits, and queues received characters for a reader. It also keeps sticky error flags so benches and FPGA debug logic can detect framing, parity and overflow faults instead of silently printing garbage.

---
 rtl/uart_rx_monitor.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx_monitor.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_monitor.sv
// UART receive monitor: oversampled serial receiver with start/parity/stop checks,
// a first-word fall-through receive FIFO and sticky error flags.
module uart_rx_monitor #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic                          rx,
    input  logic                          rd,
    output logic [DATA_BITS-1:0]          rdata,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    input  logic                          clr_err
);

    localparam int HALF   = CLKS_PER_BIT / 2;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam int AW     = $clog2(FIFO_DEPTH);

    localparam logic [BAUD_W-1:0] HALF_LOAD = BAUD_W'(HALF);
    localparam logic [BAUD_W-1:0] START_MID = BAUD_W'(2 * HALF - 1);
    localparam logic [BAUD_W-1:0] BIT_END   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic [AW:0]       DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]       ONE_CNT   = (AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic                 r_sync1;
    logic                 r_rxS;
    logic                 r_rxPrev;
    logic [BAUD_W-1:0]    r_baud;
    logic [BIT_W-1:0]     r_bitCnt;
    logic                 r_stopCnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parPend;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [AW:0]          r_count;
    logic [DATA_BITS-1:0] r_rdata;
    logic                 r_frameErr;
    logic                 r_parityErr;
    logic                 r_overrun;

    logic                 w_fall;
    logic                 w_sample;
    logic                 w_lastStop;
    logic                 w_parityBad;
    logic                 w_frameSet;
    logic                 w_goodFrame;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_overSet;
    logic [AW-1:0]        w_rptrNext;

    // The start-bit wait begins at HALF and ends at 2*HALF-1 so the mid-start sample
    // lands exactly HALF cycles after the edge even for odd bit periods.
    assign w_fall      = r_rxPrev & ~r_rxS;
    assign w_sample    = (r_state == S_START) ? (r_baud == START_MID) : (r_baud == BIT_END);
    assign w_lastStop  = (STOP_BITS == 1) || r_stopCnt;
    assign w_parityBad = (PARITY == 1) ? ~(^r_shift ^ r_rxS) : (^r_shift ^ r_rxS);
    assign w_push      = w_goodFrame && ((r_count != DEPTH_CNT) || rd);
    assign w_pop       = rd && (r_count != '0);
    assign w_overSet   = w_goodFrame && !w_push;
    assign w_rptrNext  = r_rptr + 1'b1;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_sync1  <= 1'b1;
            r_rxS    <= 1'b1;
            r_rxPrev <= 1'b1;
        end else begin
            r_sync1  <= rx;
            r_rxS    <= r_sync1;
            r_rxPrev <= r_rxS;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_frameSet  = 1'b0;
        w_goodFrame = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) w_nextState = S_START;
            end
            S_START: begin
                if (w_sample) w_nextState = r_rxS ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_sample && (r_bitCnt == LAST_BIT))
                    w_nextState = (PARITY != 0) ? S_PAR : S_STOP;
            end
            S_PAR: begin
                if (w_sample) w_nextState = S_STOP;
            end
            S_STOP: begin
                if (w_sample) begin
                    // Leaving at the stop sample gives half a bit of slack for the next start edge.
                    if (!r_rxS) begin
                        w_frameSet  = 1'b1;
                        w_nextState = S_IDLE;
                    end else if (w_lastStop) begin
                        w_goodFrame = 1'b1;
                        w_nextState = S_IDLE;
                    end
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_baud    <= '0;
            r_bitCnt  <= '0;
            r_stopCnt <= 1'b0;
            r_shift   <= '0;
            r_parPend <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_fall) begin
                r_baud    <= HALF_LOAD;
                r_bitCnt  <= '0;
                r_stopCnt <= 1'b0;
                r_parPend <= 1'b0;
            end
        end else begin
            r_baud <= w_sample ? '0 : r_baud + 1'b1;
            if (w_sample && (r_state == S_DATA)) begin
                r_shift  <= {r_rxS, r_shift[DATA_BITS-1:1]};
                r_bitCnt <= r_bitCnt + 1'b1;
            end
            if (w_sample && (r_state == S_PAR)) r_parPend <= w_parityBad;
            if (w_sample && (r_state == S_STOP)) r_stopCnt <= 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_push) r_mem[r_wptr] <= r_shift;
    end

    // rdata is a registered copy of the head so it can reset to zero and hold when drained.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_rdata <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= w_rptrNext;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            if (w_pop && (r_count > ONE_CNT))
                r_rdata <= r_mem[w_rptrNext];
            else if (w_push && ((r_count == '0) || (w_pop && (r_count == ONE_CNT))))
                r_rdata <= r_shift;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_frameErr  <= 1'b0;
            r_parityErr <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frameErr  <= w_frameSet | (r_frameErr & ~clr_err);
            r_parityErr <= (w_push & r_parPend) | (r_parityErr & ~clr_err);
            r_overrun   <= w_overSet | (r_overrun & ~clr_err);
        end
    end

    assign rdata      = r_rdata;
    assign empty      = (r_count == '0);
    assign full       = (r_count == DEPTH_CNT);
    assign count      = r_count;
    assign frame_err  = r_frameErr;
    assign parity_err = r_parityErr;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Bench for uart_rx_monitor: an 8N1 instance (A) and an 8E2 depth-4 odd-period instance (B)
// driven by directed and random frames, checked against a queue-based model of the receiver.
module tb_uart_rx_monitor;

    localparam int NA      = 16;
    localparam int NB      = 7;
    localparam int DEPTH_A = 16;
    localparam int DEPTH_B = 4;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic       rxA, rdA, clrA;
    logic [7:0] rdataA;
    logic       emptyA, fullA, feA, peA, ovA;
    logic [4:0] countA;
    logic       rxB, rdB, clrB;
    logic [7:0] rdataB;
    logic       emptyB, fullB, feB, peB, ovB;
    logic [2:0] countB;

    int errors = 0;
    int checks = 0;

    logic [7:0] qA[$];
    logic [7:0] qB[$];
    bit expFe [2];
    bit expPe [2];
    bit expOv [2];

    always #5 HCLK = ~HCLK;

    uart_rx_monitor u_a (
        .HCLK(HCLK), .HRESET(HRESET), .rx(rxA), .rd(rdA), .rdata(rdataA),
        .empty(emptyA), .full(fullA), .count(countA), .frame_err(feA),
        .parity_err(peA), .overrun(ovA), .clr_err(clrA)
    );

    uart_rx_monitor #(
        .CLKS_PER_BIT(NB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH_B)
    ) u_b (
        .HCLK(HCLK), .HRESET(HRESET), .rx(rxB), .rd(rdB), .rdata(rdataB),
        .empty(emptyB), .full(fullB), .count(countB), .frame_err(feB),
        .parity_err(peB), .overrun(ovB), .clr_err(clrB)
    );

    function automatic logic [7:0] observe(input int sel);
        return (sel != 0) ? {2'b00, countB, feB, peB, ovB} : {countA, feA, peA, ovA};
    endfunction

    // Receiver behaviour in frame terms: bad stop discards, full FIFO drops, even parity on B.
    task automatic modelFrame(input int sel, input logic [7:0] d, input logic pb,
                              input logic s0, input logic s1);
        bit stopsOk = (sel != 0) ? (s0 && s1) : s0;
        if (!stopsOk) begin
            expFe[sel] = 1'b1;
        end else if (sel == 0) begin
            if (qA.size() < DEPTH_A) qA.push_back(d);
            else expOv[0] = 1'b1;
        end else begin
            if (qB.size() < DEPTH_B) begin
                qB.push_back(d);
                if ((^d ^ pb) != 1'b0) expPe[1] = 1'b1;
            end else begin
                expOv[1] = 1'b1;
            end
        end
    endtask

    task automatic sendFrame(input int sel, input logic [7:0] d, input logic pb,
                             input logic s0, input logic s1, output int lat);
        logic [11:0] bits;
        logic [7:0]  snap;
        int          nb;
        int          n;
        n = (sel != 0) ? NB : NA;
        snap = '0;
        if (sel == 0) begin
            bits = {2'b11, s0, d, 1'b0};
            nb = 10;
        end else begin
            bits = {s1, s0, pb, d, 1'b0};
            nb = 12;
        end
        lat = -1;
        for (int i = 0; i < nb; i++) begin
            if (i == nb - 1) snap = observe(sel);
            if (sel == 0) rxA = bits[i];
            else rxB = bits[i];
            for (int j = 1; j <= n; j++) begin
                @(negedge HCLK);
                if ((i == nb - 1) && (lat < 0) && (observe(sel) != snap)) lat = j;
            end
        end
        if (sel == 0) rxA = 1'b1;
        else rxB = 1'b1;
        repeat (n + 4) @(negedge HCLK);
        modelFrame(sel, d, pb, s0, s1);
    endtask

    task automatic popOne(input int sel);
        @(negedge HCLK);
        if (sel == 0) rdA = 1'b1;
        else rdB = 1'b1;
        @(negedge HCLK);
        rdA = 1'b0;
        rdB = 1'b0;
        if ((sel == 0) && (qA.size() > 0)) qA.delete(0);
        if ((sel != 0) && (qB.size() > 0)) qB.delete(0);
    endtask

    task automatic clrPulse(input int sel);
        @(negedge HCLK);
        if (sel == 0) clrA = 1'b1;
        else clrB = 1'b1;
        @(negedge HCLK);
        clrA = 1'b0;
        clrB = 1'b0;
        expFe[sel] = 1'b0;
        expPe[sel] = 1'b0;
        expOv[sel] = 1'b0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        rxA = 1'b1; rdA = 1'b0; clrA = 1'b0;
        rxB = 1'b1; rdB = 1'b0; clrB = 1'b0;
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        checks++; if (rdataA !== 8'h00) begin errors++; $display("[TB] FAIL reset_rdata: got %h want 00", rdataA); end
        checks++; if (emptyA !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b want 1", emptyA); end
        checks++; if (fullA !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b want 0", fullA); end
        checks++; if (countA !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", countA); end
        checks++; if ({feA, peA, ovA} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b want 000", {feA, peA, ovA}); end
        checks++; if ({emptyB, countB, rdataB} !== {1'b1, 3'd0, 8'h00}) begin errors++; $display("[TB] FAIL reset_b: got %b/%0d/%h want 1/0/00", emptyB, countB, rdataB); end
    endtask

    task automatic test_basic_char();
        int lat;
        sendFrame(0, 8'h41, 1'b0, 1'b1, 1'b1, lat);
        checks++; if ((lat < NA / 2 + 1) || (lat > NA / 2 + 4)) begin errors++; $display("[TB] FAIL basic_push_latency: got %0d want %0d..%0d", lat, NA / 2 + 1, NA / 2 + 4); end
        checks++; if (rdataA !== 8'h41) begin errors++; $display("[TB] FAIL basic_rdata: got %h want 41", rdataA); end
        checks++; if ({emptyA, countA} !== {1'b0, 5'd1}) begin errors++; $display("[TB] FAIL basic_count: got empty=%b count=%0d want 0/1", emptyA, countA); end
        popOne(0);
        checks++; if ({emptyA, countA} !== {1'b1, 5'd0}) begin errors++; $display("[TB] FAIL basic_pop: got empty=%b count=%0d want 1/0", emptyA, countA); end
        checks++; if (rdataA !== 8'h41) begin errors++; $display("[TB] FAIL basic_rdata_hold: got %h want 41", rdataA); end
        popOne(0);
        checks++; if ({emptyA, countA} !== {1'b1, 5'd0}) begin errors++; $display("[TB] FAIL empty_pop_ignored: got empty=%b count=%0d want 1/0", emptyA, countA); end
    endtask

    task automatic test_parity();
        int lat;
        sendFrame(1, 8'h03, 1'b1, 1'b1, 1'b1, lat);
        checks++; if ({countB, rdataB} !== {3'd1, 8'h03}) begin errors++; $display("[TB] FAIL parity_queued: got %0d/%h want 1/03", countB, rdataB); end
        checks++; if (peB !== expPe[1]) begin errors++; $display("[TB] FAIL parity_err_set: got %b want %b", peB, expPe[1]); end
        clrPulse(1);
        checks++; if (peB !== 1'b0) begin errors++; $display("[TB] FAIL parity_clr: got %b want 0", peB); end
        sendFrame(1, 8'h03, 1'b0, 1'b1, 1'b1, lat);
        checks++; if ({peB, countB} !== {expPe[1], 3'(qB.size())}) begin errors++; $display("[TB] FAIL parity_good: got pe=%b count=%0d want %b/%0d", peB, countB, expPe[1], qB.size()); end
        while (qB.size() > 0) begin
            checks++; if (rdataB !== qB[0]) begin errors++; $display("[TB] FAIL parity_drain: got %h want %h", rdataB, qB[0]); end
            popOne(1);
        end
    endtask

    task automatic test_framing();
        int lat;
        sendFrame(0, 8'h55, 1'b0, 1'b0, 1'b1, lat);
        checks++; if ({feA, emptyA, countA} !== {1'b1, 1'b1, 5'd0}) begin errors++; $display("[TB] FAIL frame_bad_stop: got fe=%b empty=%b count=%0d want 1/1/0", feA, emptyA, countA); end
        checks++; if ((lat < NA / 2 + 1) || (lat > NA / 2 + 4)) begin errors++; $display("[TB] FAIL frame_err_latency: got %0d want %0d..%0d", lat, NA / 2 + 1, NA / 2 + 4); end
        sendFrame(0, 8'hAA, 1'b0, 1'b1, 1'b1, lat);
        checks++; if ({rdataA, countA, feA} !== {8'hAA, 5'd1, 1'b1}) begin errors++; $display("[TB] FAIL frame_recover: got %h/%0d/%b want AA/1/1", rdataA, countA, feA); end
        clrPulse(0);
        popOne(0);
    endtask

    task automatic test_overflow();
        int lat;
        for (int v = 8'h10; v <= 8'h14; v++) sendFrame(1, 8'(v), ^(8'(v)), 1'b1, 1'b1, lat);
        checks++; if ({fullB, ovB, peB, countB} !== {1'b1, 1'b1, 1'b0, 3'd4}) begin errors++; $display("[TB] FAIL overflow_state: got full=%b ov=%b pe=%b count=%0d want 1/1/0/4", fullB, ovB, peB, countB); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rdataB !== qB[0]) begin errors++; $display("[TB] FAIL overflow_pop%0d: got %h want %h", i, rdataB, qB[0]); end
            popOne(1);
        end
        checks++; if ({emptyB, countB} !== {1'b1, 3'd0}) begin errors++; $display("[TB] FAIL overflow_drained: got %b/%0d want 1/0", emptyB, countB); end
        clrPulse(1);
    endtask

    task automatic test_false_start();
        int lat;
        @(negedge HCLK);
        rxA = 1'b0;
        repeat (4) @(negedge HCLK);
        rxA = 1'b1;
        repeat (NA / 2 + 4) @(negedge HCLK);
        checks++; if ({countA, feA, peA, ovA} !== 8'h00) begin errors++; $display("[TB] FAIL false_start_quiet: got count=%0d flags=%b want 0/000", countA, {feA, peA, ovA}); end
        sendFrame(0, 8'h5A, 1'b0, 1'b1, 1'b1, lat);
        checks++; if ({rdataA, countA, feA, peA, ovA} !== {8'h5A, 5'd1, 3'b000}) begin errors++; $display("[TB] FAIL false_start_next: got %h/%0d/%b want 5A/1/000", rdataA, countA, {feA, peA, ovA}); end
        popOne(0);
    endtask

    task automatic test_reset_mid_frame();
        int         lat;
        logic [7:0] d = 8'h7E;
        sendFrame(0, 8'h33, 1'b0, 1'b1, 1'b1, lat);
        rxA = 1'b0;
        repeat (NA) @(negedge HCLK);
        for (int i = 0; i < 4; i++) begin
            rxA = d[i];
            repeat (NA) @(negedge HCLK);
        end
        HRESET = 1'b1;
        rxA = 1'b1;
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        qA.delete(); qB.delete();
        for (int s = 0; s < 2; s++) begin expFe[s] = 1'b0; expPe[s] = 1'b0; expOv[s] = 1'b0; end
        repeat (2 * NA) @(negedge HCLK);
        checks++; if ({emptyA, countA, feA, peA, ovA} !== {1'b1, 5'd0, 3'b000}) begin errors++; $display("[TB] FAIL midreset_state: got empty=%b count=%0d flags=%b want 1/0/000", emptyA, countA, {feA, peA, ovA}); end
        sendFrame(0, 8'h7E, 1'b0, 1'b1, 1'b1, lat);
        repeat (2 * NA) @(negedge HCLK);
        checks++; if ({rdataA, countA} !== {8'h7E, 5'd1}) begin errors++; $display("[TB] FAIL midreset_resend: got %h/%0d want 7E/1", rdataA, countA); end
        popOne(0);
    endtask

    task automatic test_random();
        int         lat;
        int         sel;
        logic [7:0] d;
        logic       pb, s0, s1;
        for (int it = 0; it < 30; it++) begin
            sel = int'($urandom_range(0, 1));
            d   = 8'($urandom);
            pb  = (^d) ^ ($urandom_range(0, 3) == 0);
            s0  = ($urandom_range(0, 7) != 0);
            s1  = ($urandom_range(0, 7) != 0);
            sendFrame(sel, d, pb, s0, s1, lat);
            if (sel == 0) begin
                checks++; if ({countA, emptyA, fullA} !== {5'(qA.size()), qA.size() == 0, qA.size() == DEPTH_A}) begin errors++; $display("[TB] FAIL rand%0d_fifoA: got %0d/%b/%b want %0d", it, countA, emptyA, fullA, qA.size()); end
                checks++; if ({feA, peA, ovA} !== {expFe[0], expPe[0], expOv[0]}) begin errors++; $display("[TB] FAIL rand%0d_flagsA: got %b want %b", it, {feA, peA, ovA}, {expFe[0], expPe[0], expOv[0]}); end
            end else begin
                checks++; if ({countB, emptyB, fullB} !== {3'(qB.size()), qB.size() == 0, qB.size() == DEPTH_B}) begin errors++; $display("[TB] FAIL rand%0d_fifoB: got %0d/%b/%b want %0d", it, countB, emptyB, fullB, qB.size()); end
                checks++; if ({feB, peB, ovB} !== {expFe[1], expPe[1], expOv[1]}) begin errors++; $display("[TB] FAIL rand%0d_flagsB: got %b want %b", it, {feB, peB, ovB}, {expFe[1], expPe[1], expOv[1]}); end
            end
            for (int k = int'($urandom_range(0, 2)); k > 0; k--) begin
                if ((sel == 0) && (qA.size() > 0)) begin
                    checks++; if (rdataA !== qA[0]) begin errors++; $display("[TB] FAIL rand%0d_headA: got %h want %h", it, rdataA, qA[0]); end
                end
                if ((sel != 0) && (qB.size() > 0)) begin
                    checks++; if (rdataB !== qB[0]) begin errors++; $display("[TB] FAIL rand%0d_headB: got %h want %h", it, rdataB, qB[0]); end
                end
                popOne(sel);
            end
            if ($urandom_range(0, 3) == 0) clrPulse(sel);
        end
    endtask

    initial begin
        $display("[TB] uart_rx_monitor bench starting");
        test_reset();
        test_basic_char();
        test_parity();
        test_framing();
        test_overflow();
        test_false_start();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
